multi_cycle_proc: RTL and testbench

Multicycle MIPS-subset processor core: an FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared ALU, with an internal 32x32 register file. Instruction memory is combinational-read; data memory sits behind a req/ready handshake so slow memories insert wait states. It replaces the single-cycle core for targets with multi-cycle data memory, and adds halt detection and a retired-instruction counter.

---
 rtl/multi_cycle_proc.sv | 153 +++++++++++++++
 tb/tb_multi_cycle_proc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_proc.sv
// multi_cycle_proc: multicycle MIPS-subset core with shared ALU, handshake data memory, halt detection and retire counter
module multi_cycle_proc #(
  parameter int DADDR_W  = 6,
  parameter int RETIRE_W = 32
) (
  input  logic                CLK,
  input  logic                Reset_L,
  input  logic [31:0]         startPC,
  output logic [31:0]         imem_addr,
  input  logic [31:0]         imem_data,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DADDR_W-1:0]  dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_ready,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, nextState;
  logic [31:0] pc, npc, ir, regA, regB, aluOut, mdr, aluRes;
  logic [31:0] rf [32];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt, wbReg;
  logic [31:0] sext, zext, rsVal, rtVal, wbData;
  logic isR, legal, isJ, isJal, isJr, isBeq, isBne, isLw, isSw, brTaken, wbEn;
  assign op     = ir[31:26];
  assign funct  = ir[5:0];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign sext   = {{16{ir[15]}}, ir[15:0]};
  assign zext   = {16'h0000, ir[15:0]};
  assign rsVal  = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rtVal  = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign isR    = op == 6'h00;
  assign isJr   = isR && funct == 6'h08;
  assign isJ    = op == 6'h02;
  assign isJal  = op == 6'h03;
  assign isBeq  = op == 6'h04;
  assign isBne  = op == 6'h05;
  assign isLw   = op == 6'h23;
  assign isSw   = op == 6'h2B;
  assign brTaken = isBeq ? (regA == regB) : (regA != regB);
  assign wbReg  = isJal ? 5'd31 : isR ? rd : rt;
  assign wbData = isJal ? npc : isLw ? mdr : aluOut;
  assign wbEn   = (state == WB || (state == DECODE && isJal)) && wbReg != 5'd0;
  assign imem_addr  = pc;
  assign dmem_req   = state == MEM;
  assign dmem_we    = dmem_req && isSw;
  assign dmem_addr  = aluOut[DADDR_W+1:2];
  assign dmem_wdata = regB;
  assign halted     = state == HALT;
  // flag every opcode/funct outside the supported subset
  always_comb begin
    legal = 1'b0;
    if (isR)
      case (funct)
        6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    else
      case (op)
        6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
        6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: legal = 1'b1;
        default: legal = 1'b0;
      endcase
  end
  // shared ALU; loads and stores reuse the add path for address generation
  always_comb begin
    aluRes = '0;
    if (isR)
      case (funct)
        6'h20, 6'h21: aluRes = regA + regB;
        6'h22, 6'h23: aluRes = regA - regB;
        6'h24: aluRes = regA & regB;
        6'h25: aluRes = regA | regB;
        6'h26: aluRes = regA ^ regB;
        6'h27: aluRes = ~(regA | regB);
        6'h2A: aluRes = {31'd0, $signed(regA) < $signed(regB)};
        6'h2B: aluRes = {31'd0, regA < regB};
        6'h00: aluRes = regB << shamt;
        6'h02: aluRes = regB >> shamt;
        6'h03: aluRes = $signed(regB) >>> shamt;
        default: aluRes = '0;
      endcase
    else
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: aluRes = regA + sext;
        6'h0A: aluRes = {31'd0, $signed(regA) < $signed(sext)};
        6'h0B: aluRes = {31'd0, regA < sext};
        6'h0C: aluRes = regA & zext;
        6'h0D: aluRes = regA | zext;
        6'h0E: aluRes = regA ^ zext;
        6'h0F: aluRes = {ir[15:0], 16'h0000};
        default: aluRes = '0;
      endcase
  end
  // instruction sequencing; jumps finish in DECODE, branches in EXEC, stores after MEM
  always_comb begin
    nextState = state;
    case (state)
      FETCH:   nextState = DECODE;
      DECODE:  nextState = !legal ? HALT : (isJ || isJal || isJr) ? FETCH : EXEC;
      EXEC:    nextState = (isBeq || isBne) ? FETCH : (isLw || isSw) ? MEM : WB;
      MEM:     nextState = !dmem_ready ? MEM : isSw ? FETCH : WB;
      WB:      nextState = FETCH;
      default: nextState = HALT;
    endcase
  end
  // datapath registers, PC steering and saturating retire count
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state   <= FETCH;
      pc      <= startPC;
      npc     <= startPC;
      ir      <= '0;
      regA    <= '0;
      regB    <= '0;
      aluOut  <= '0;
      mdr     <= '0;
      retired <= '0;
    end else begin
      state <= nextState;
      if (nextState == FETCH && retired != '1) retired <= retired + 1'b1;
      case (state)
        FETCH: begin
          ir  <= imem_data;
          pc  <= pc + 32'd4;
          npc <= pc + 32'd4;
        end
        DECODE: begin
          regA <= rsVal;
          regB <= rtVal;
          pc   <= !legal ? pc - 32'd4 : isJr ? rsVal : (isJ || isJal) ? {npc[31:28], ir[25:0], 2'b00} : pc;
        end
        EXEC: begin
          aluOut <= aluRes;
          if ((isBeq || isBne) && brTaken) pc <= npc + (sext << 2);
        end
        MEM: if (dmem_ready) mdr <= dmem_rdata;
        default: ;
      endcase
    end
  end
  // register file, not reset; r0 writes are dropped by wbEn
  always_ff @(posedge CLK) begin
    if (wbEn) rf[wbReg] <= wbData;
  end
endmodule

// File: tb/tb_multi_cycle_proc.sv
// tb_multi_cycle_proc: directed programs checked cycle by cycle against an instruction-level model
module tb_multi_cycle_proc;
  localparam int DADDR_W = 6;
  localparam int RETIRE_W = 32;
  logic CLK = 1'b0;
  logic Reset_L = 1'b1;
  logic [31:0] startPC = 32'h0;
  logic [31:0] imem_addr, imem_data, dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic dmem_req, dmem_we, halted;
  logic dmem_ready = 1'b0;
  logic [DADDR_W-1:0] dmem_addr;
  logic [RETIRE_W-1:0] retired;
  logic [31:0] imem [1024];
  logic [31:0] dmem [64];
  logic [31:0] rf [32];
  logic [31:0] mpc, mret, pgmAddr;
  logic mHalted;
  int waits = 0;
  int vectors = 0;
  int miscompares = 0;
  int cyc;

  multi_cycle_proc #(.DADDR_W(DADDR_W), .RETIRE_W(RETIRE_W)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;
  assign imem_data = imem[imem_addr[11:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got %0d miscompares so far", miscompares);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] iT(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rT(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] jT(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  task automatic put(input logic [31:0] w);
    imem[pgmAddr[11:2]] = w;
    pgmAddr += 32'd4;
  endtask

  task automatic doReset(input logic [31:0] pc);
    @(negedge CLK);
    startPC = pc;
    Reset_L = 1'b0;
    dmem_ready = 1'b1;
    #1;
    chk("rst_pc", imem_addr, pc);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    @(negedge CLK);
    Reset_L = 1'b1;
    #1;
    mpc = pc;
    mret = 0;
    mHalted = 1'b0;
  endtask

  // executes one instruction in the model while checking the DUT each cycle; entered and left at a FETCH sample point
  task automatic runInstr(output int ncyc);
    logic [31:0] ir, a, b, se, ze, res, npc, ea;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh, dst;
    logic ok, wr, isMem, isSt, expReq;
    ir = imem[mpc[11:2]];
    op = ir[31:26]; fn = ir[5:0]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11]; sh = ir[10:6];
    a = rf[rs]; b = rf[rt];
    se = {{16{ir[15]}}, ir[15:0]};
    ze = {16'h0, ir[15:0]};
    ea = a + se;
    npc = mpc + 32'd4;
    ok = 1'b1; wr = 1'b1; dst = rt; res = 0; isMem = 1'b0; isSt = 1'b0; ncyc = 4;
    if (op == 6'h00) begin
      dst = rd;
      case (fn)
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: res = $signed(b) >>> sh;
        6'h08: begin wr = 1'b0; npc = a; ncyc = 2; end
        default: ok = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: res = a + se;
        6'h0A: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0B: res = (a < se) ? 32'd1 : 32'd0;
        6'h0C: res = a & ze;
        6'h0D: res = a | ze;
        6'h0E: res = a ^ ze;
        6'h0F: res = {ir[15:0], 16'h0};
        6'h02: begin wr = 1'b0; ncyc = 2; npc = {npc[31:28], ir[25:0], 2'b00}; end
        6'h03: begin dst = 5'd31; res = mpc + 32'd4; ncyc = 2; npc = {npc[31:28], ir[25:0], 2'b00}; end
        6'h04: begin wr = 1'b0; ncyc = 3; if (a == b) npc = mpc + 32'd4 + (se << 2); end
        6'h05: begin wr = 1'b0; ncyc = 3; if (a != b) npc = mpc + 32'd4 + (se << 2); end
        6'h23: begin isMem = 1'b1; ncyc = 5; res = dmem[ea[7:2]]; end
        6'h2B: begin wr = 1'b0; isMem = 1'b1; isSt = 1'b1; ncyc = 4; end
        default: ok = 1'b0;
      endcase
    end
    chk("fetch_pc", imem_addr, mpc);
    chk("fetch_retired", retired, mret);
    chk("fetch_halted", halted, 0);
    chk("fetch_req", dmem_req, 0);
    if (!ok) begin
      for (int k = 1; k <= 6; k++) begin
        @(negedge CLK);
        dmem_ready = 1'b1;
        #1;
        if (k == 1) chk("decode_pc", imem_addr, mpc + 32'd4);
        chk("halted", halted, (k >= 2) ? 32'd1 : 32'd0);
        if (k >= 2) begin
          chk("halt_pc", imem_addr, mpc);
          chk("halt_req", dmem_req, 0);
          chk("halt_retired", retired, mret);
        end
      end
      mHalted = 1'b1;
      ncyc = 2;
      return;
    end
    if (isMem) ncyc += waits;
    for (int k = 1; k < ncyc; k++) begin
      @(negedge CLK);
      dmem_ready = !(isMem && k >= 3 && k < 3 + waits);
      dmem_rdata = isMem ? dmem[ea[7:2]] : 32'hBAD0_0000 + k;
      #1;
      if (k == 1) chk("decode_pc", imem_addr, mpc + 32'd4);
      expReq = isMem && k >= 3 && k <= 3 + waits;
      chk("dmem_req", dmem_req, expReq);
      if (expReq) begin
        chk("dmem_we", dmem_we, isSt);
        chk("dmem_addr", dmem_addr, ea[7:2]);
        if (isSt) chk("dmem_wdata", dmem_wdata, b);
      end
    end
    @(negedge CLK);
    dmem_ready = 1'b1;
    #1;
    if (wr && dst != 5'd0) rf[dst] = res;
    if (isSt) dmem[ea[7:2]] = b;
    mpc = npc;
    mret++;
  endtask

  task automatic run(input int n);
    int c;
    for (int i = 0; i < n; i++) if (!mHalted) runInstr(c);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    mHalted = 1'b0;
    // arithmetic, memory with wait states, misaligned addressing
    pgmAddr = 32'h100;
    put(iT(6'h08, 0, 1, 16'd5));
    put(iT(6'h08, 0, 2, 16'hFFFD));
    put(rT(1, 2, 3, 0, 6'h20));
    put(iT(6'h2B, 0, 3, 16'd8));
    put(iT(6'h23, 0, 4, 16'd8));
    put(rT(2, 1, 5, 0, 6'h22));
    put(rT(1, 2, 6, 0, 6'h24));
    put(rT(1, 2, 7, 0, 6'h25));
    put(rT(1, 2, 8, 0, 6'h26));
    put(rT(1, 2, 9, 0, 6'h27));
    put(rT(2, 1, 10, 0, 6'h2A));
    put(rT(2, 1, 11, 0, 6'h2B));
    put(rT(0, 2, 12, 4, 6'h00));
    put(rT(0, 2, 13, 4, 6'h02));
    put(rT(0, 2, 14, 4, 6'h03));
    put(iT(6'h09, 1, 15, 16'hFFFF));
    put(iT(6'h0A, 2, 16, 16'h0000));
    put(iT(6'h0B, 1, 17, 16'hFFFF));
    put(iT(6'h0C, 2, 18, 16'hF0F0));
    put(iT(6'h0D, 1, 19, 16'h8000));
    put(iT(6'h0E, 2, 20, 16'hFFFF));
    put(iT(6'h0F, 0, 21, 16'h1234));
    put(rT(1, 2, 22, 0, 6'h23));
    put(rT(1, 2, 23, 0, 6'h21));
    for (int r = 5; r <= 23; r++) put(iT(6'h2B, 0, 5'(r), 16'(4 * r)));
    put(iT(6'h2B, 0, 3, 16'h000B));
    put(iT(6'h23, 0, 24, 16'h0015));
    put(iT(6'h2B, 0, 24, 16'd100));
    doReset(32'h100);
    run(3);
    chk("lit_pc_10C", imem_addr, 32'h10C);
    chk("lit_retired_3", retired, 3);
    waits = 3;
    runInstr(cyc);
    chk("lit_sw_cycles", cyc, 7);
    chk("lit_mem2", dmem[2], 2);
    runInstr(cyc);
    chk("lit_lw_cycles", cyc, 8);
    chk("lit_r4", rf[4], 2);
    waits = 1;
    run(43);
    chk("lit_r5", rf[5], 32'hFFFF_FFF8);
    chk("lit_r13", rf[13], 32'h0FFF_FFFF);
    chk("lit_r14", rf[14], 32'hFFFF_FFFF);
    chk("lit_r17", rf[17], 1);
    chk("lit_r21", rf[21], 32'h1234_0000);
    chk("lit_r24", rf[24], 32'hFFFF_FFF8);
    // branches taken and not taken
    waits = 0;
    pgmAddr = 32'h100; put(iT(6'h04, 1, 1, 16'd2));
    pgmAddr = 32'h10C; put(iT(6'h05, 1, 1, 16'd2));
    put(iT(6'h04, 1, 2, 16'd3));
    put(iT(6'h05, 1, 2, 16'hFFFB));
    doReset(32'h100);
    runInstr(cyc);
    chk("lit_beq_cycles", cyc, 3);
    chk("lit_beq_target", imem_addr, 32'h10C);
    run(1);
    chk("lit_bne_nt", imem_addr, 32'h110);
    run(2);
    chk("lit_bne_back", imem_addr, 32'h104);
    run(1);
    // illegal opcode halts
    pgmAddr = 32'h100;
    put(iT(6'h08, 0, 1, 16'd5));
    put(iT(6'h08, 0, 2, 16'hFFFD));
    put(32'hFC00_0000);
    doReset(32'h100);
    run(3);
    chk("lit_halt_pc", imem_addr, 32'h108);
    chk("lit_halt_retired", retired, 2);
    chk("lit_halt_flag", halted, 1);
    // jal / jr round trip
    pgmAddr = 32'h200; put(jT(6'h03, 32'h40)); put(iT(6'h2B, 0, 31, 16'd24));
    pgmAddr = 32'h040; put(rT(31, 0, 0, 0, 6'h08));
    doReset(32'h200);
    runInstr(cyc);
    chk("lit_jal_cycles", cyc, 2);
    chk("lit_jal_target", imem_addr, 32'h40);
    runInstr(cyc);
    chk("lit_jr_cycles", cyc, 2);
    chk("lit_jr_return", imem_addr, 32'h204);
    run(1);
    chk("lit_r31", dmem[6], 32'h204);
    // reset during a load's memory wait
    dmem[4] = 32'hDEAD_BEEF;
    pgmAddr = 32'h300; put(iT(6'h23, 0, 4, 16'd16)); put(iT(6'h2B, 0, 4, 16'd20));
    doReset(32'h300);
    chk("mr_fetch_pc", imem_addr, 32'h300);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      dmem_ready = 1'b0;
      dmem_rdata = 32'hDEAD_BEEF;
      #1;
      if (k >= 3) chk("mr_req_wait", dmem_req, 1);
    end
    @(negedge CLK);
    startPC = 32'h304;
    Reset_L = 1'b0;
    #1;
    chk("mr_req_drop", dmem_req, 0);
    chk("mr_pc", imem_addr, 32'h304);
    chk("mr_retired", retired, 0);
    chk("mr_halted", halted, 0);
    @(negedge CLK);
    Reset_L = 1'b1;
    dmem_ready = 1'b1;
    #1;
    mpc = 32'h304;
    mret = 0;
    mHalted = 1'b0;
    run(1);
    chk("lit_r4_kept", dmem[5], 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
